// File: rtl/shiftreg_seq_ctrl.sv
// Word-to-serial sequencer that owns the control pins of an N-bit SIPO shift register.
// Optional sr_q_i-vs-word self-check is built when SHIFTREG_SEQ_CHECK_EN is defined.
module shiftreg_seq_ctrl #(
  parameter int MSB = 8,
  parameter int GAP = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [MSB-1:0] word_i,
  input  logic           dir_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic           abort_i,
  output logic           sr_en_o,
  output logic           sr_dir_o,
  output logic           sr_data_o,
  input  logic [MSB-1:0] sr_q_i,
  output logic [MSB-1:0] result_o,
  output logic           result_valid_o,
  output logic           busy_o,
  output logic           err_o
);

  localparam int CW = $clog2(MSB);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(MSB - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_GAP
  } state_t;

  state_t         state, state_d;
  logic [MSB-1:0] word_q, word_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [GW-1:0]  gap_cnt, gap_d;
  logic           sr_en_q, sr_en_d;
  logic           sr_dir_q, sr_dir_d;
  logic           sr_data_q, sr_data_d;
  logic [MSB-1:0] result_q, result_d;
  logic           result_valid_q, result_valid_d;

  // Bit sent on shift number idx: MSB-first for left shifts, LSB-first for right shifts.
  function automatic logic pick_bit(input logic [MSB-1:0] w, input logic d,
                                    input logic [CW-1:0] idx);
    pick_bit = d ? w[idx] : w[LAST_BIT - idx];
  endfunction

  assign ready_o        = (state == S_IDLE);
  assign busy_o         = (state != S_IDLE);
  assign sr_en_o        = sr_en_q;
  assign sr_dir_o       = sr_dir_q;
  assign sr_data_o      = sr_data_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      word_q         <= '0;
      cnt            <= '0;
      gap_cnt        <= '0;
      sr_en_q        <= 1'b0;
      sr_dir_q       <= 1'b0;
      sr_data_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state          <= state_d;
      word_q         <= word_d;
      cnt            <= cnt_d;
      gap_cnt        <= gap_d;
      sr_en_q        <= sr_en_d;
      sr_dir_q       <= sr_dir_d;
      sr_data_q      <= sr_data_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // NOTE: every signal gets a default before the case, so no branch can infer a latch.
  always_comb begin
    state_d        = state;
    word_d         = word_q;
    cnt_d          = cnt;
    gap_d          = gap_cnt;
    sr_en_d        = 1'b0;
    sr_dir_d       = sr_dir_q;
    sr_data_d      = sr_data_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    case (state)
      S_IDLE: begin
        // Abort is deliberately not looked at here: a word offered with abort is accepted.
        if (valid_i && ready_o) begin
          state_d   = S_SHIFT;
          word_d    = word_i;
          sr_dir_d  = dir_i;
          cnt_d     = '0;
          sr_en_d   = 1'b1;
          sr_data_d = pick_bit(word_i, dir_i, '0);
        end
      end
      S_SHIFT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt == LAST_BIT) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d     = cnt + 1'b1;
          sr_en_d   = 1'b1;
          sr_data_d = pick_bit(word_q, sr_dir_q, cnt + 1'b1);
        end
      end
      S_CAPTURE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          result_d       = sr_q_i;
          result_valid_d = 1'b1;
          gap_d          = '0;
          state_d        = (GAP > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == LAST_GAP) state_d = S_IDLE;
        else                     gap_d   = gap_cnt + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SHIFTREG_SEQ_CHECK_EN
  logic err_q;

  // Sticky until reset; the result strobe still fires on a mismatch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                                  err_q <= 1'b0;
    else if (state == S_CAPTURE && !abort_i && sr_q_i != word_q) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

`ifndef SYNTHESIS
  a_single_strobe: assert property (@(posedge clk_i) disable iff (rst_i)
    result_valid_o |=> !result_valid_o);
  a_no_accept_while_shifting: assert property (@(posedge clk_i) disable iff (rst_i)
    sr_en_o |-> !ready_o);
  a_dir_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (busy_o && $past(busy_o)) |-> (sr_dir_o == $past(sr_dir_o)));
`endif

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Bench for shiftreg_seq_ctrl: GAP=2 and GAP=0 instances share stimulus, each driving its own
// shift-register stub, checked every cycle against a timeline model of the word protocol.
module tb_shiftreg_seq_ctrl;

  localparam int W  = 8;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] word;
  logic dir, valid, abort;

  logic [NI-1:0]        ready, sr_en, sr_dir, sr_data, rv, busy, err;
  logic [NI-1:0][W-1:0] sr_q, result;

  always #5 clk = ~clk;

  shiftreg_seq_ctrl #(.MSB(W), .GAP(2)) u_gap2 (
    .clk_i(clk), .rst_i(rst), .word_i(word), .dir_i(dir), .valid_i(valid),
    .ready_o(ready[0]), .abort_i(abort), .sr_en_o(sr_en[0]), .sr_dir_o(sr_dir[0]),
    .sr_data_o(sr_data[0]), .sr_q_i(sr_q[0]), .result_o(result[0]),
    .result_valid_o(rv[0]), .busy_o(busy[0]), .err_o(err[0]));

  shiftreg_seq_ctrl #(.MSB(W), .GAP(0)) u_gap0 (
    .clk_i(clk), .rst_i(rst), .word_i(word), .dir_i(dir), .valid_i(valid),
    .ready_o(ready[1]), .abort_i(abort), .sr_en_o(sr_en[1]), .sr_dir_o(sr_dir[1]),
    .sr_data_o(sr_data[1]), .sr_q_i(sr_q[1]), .result_o(result[1]),
    .result_valid_o(rv[1]), .busy_o(busy[1]), .err_o(err[1]));

  // Shift register stubs: dir 0 shifts left (data into LSB), dir 1 shifts right (data into MSB).
  always @(posedge clk)
    for (int i = 0; i < NI; i++)
      if (sr_en[i])
        sr_q[i] <= sr_dir[i] ? {sr_data[i], sr_q[i][W-1:1]} : {sr_q[i][W-2:0], sr_data[i]};

  // Timeline model: edge numbers counted from the accepting edge.
  typedef struct {
    bit           fl;        // word in flight
    int           acc;       // edge that accepted it
    int           ready_at;  // ready from this edge on
    logic [W-1:0] word;
    bit           dir;
    logic [W-1:0] result;
    bit           strobe;
  } mdl_t;

  typedef struct {
    int           inst;
    int           c;
    logic [W-1:0] v;
  } strobe_t;

  mdl_t    m [NI];
  strobe_t strobes[$];
  int      cyc;
  int      n_checks;
  int      n_errors;

  function automatic int gap_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // The k-th bit to go out on the serial line.
  function automatic bit exp_bit(logic [W-1:0] w, bit d, int k);
    return d ? w[k] : w[W-1-k];
  endfunction

  task automatic check(string nm, int idx, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] at cycle %0d: got %0h, expected %0h", nm, idx, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m[i].fl       = 0;
      m[i].acc      = 0;
      m[i].ready_at = cyc;
      m[i].word     = '0;
      m[i].dir      = 0;
      m[i].result   = '0;
      m[i].strobe   = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int d;
      m[i].strobe = 0;
      if (m[i].fl) begin
        d = cyc - m[i].acc;
        if (abort && d >= 1 && d <= W + 1) begin
          m[i].fl       = 0;
          m[i].ready_at = cyc;
        end else if (d == W + 1) begin
          m[i].result   = m[i].word;
          m[i].strobe   = 1;
          m[i].fl       = 0;
          m[i].ready_at = cyc + gap_of(i);
        end
      end else if (cyc - 1 >= m[i].ready_at && valid) begin
        m[i].fl   = 1;
        m[i].acc  = cyc;
        m[i].word = word;
        m[i].dir  = dir;
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      int k;
      bit exp_en, exp_ready;
      k         = cyc - m[i].acc;
      exp_en    = m[i].fl && k <= W - 1;
      exp_ready = !m[i].fl && cyc >= m[i].ready_at;
      check("ready", i, ready[i], exp_ready);
      check("busy", i, busy[i], !exp_ready);
      check("sr_en", i, sr_en[i], exp_en);
      check("sr_dir", i, sr_dir[i], m[i].dir);
      if (exp_en) check("sr_data", i, sr_data[i], exp_bit(m[i].word, m[i].dir, k));
      check("result_valid", i, rv[i], m[i].strobe);
      check("result", i, result[i], m[i].result);
      check("err", i, err[i], 1'b0);
      if (rv[i]) strobes.push_back('{inst: i, c: cyc, v: result[i]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready[0] && ready[1]) && n < 100) begin
      step();
      n++;
    end
    check("idle_timeout", 0, n < 100, 1'b1);
  endtask

  // Sends one word; reports the bits seen on instance 0's serial line (first bit in the MSB)
  // plus strobe and ready latencies, counted in edges after the accepting edge.
  task automatic run_word(input logic [W-1:0] w, input logic d, output logic [W-1:0] seq,
                          output int rv_lat, output int rdy_lat, output logic [W-1:0] res,
                          output logic rdy1_at_strobe);
    int t0, n;
    wait_idle();
    word  = w;
    dir   = d;
    valid = 1'b1;
    step();
    valid = 1'b0;
    t0    = cyc;
    seq   = '0;
    for (int k = 0; k < W; k++) begin
      seq = {seq[W-2:0], sr_data[0]};
      if (k < W - 1) step();
    end
    n = 0;
    while (!rv[0] && n < 40) begin step(); n++; end
    rv_lat         = cyc - t0;
    res            = result[0];
    rdy1_at_strobe = ready[1];
    n = 0;
    while (!ready[0] && n < 40) begin step(); n++; end
    rdy_lat = cyc - t0;
  endtask

  initial begin
    logic [W-1:0] seq, res;
    logic         r1;
    int           rv_lat, rdy_lat, n1;
    int           sc[2];
    logic [W-1:0] sv[2];

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    word     = '0;
    dir      = 1'b0;
    valid    = 1'b0;
    abort    = 1'b0;
    model_reset();
    step();
    step();
    for (int i = 0; i < NI; i++) begin
      check("rst_ready", i, ready[i], 1'b1);
      check("rst_sr_en", i, sr_en[i], 1'b0);
      check("rst_result", i, result[i], '0);
    end
    rst = 1'b0;
    step();

    // 0xA5 left: serial line 1,0,1,0,0,1,0,1; strobe after edge T+9 (cycle T+10); ready T+12.
    run_word(8'hA5, 1'b0, seq, rv_lat, rdy_lat, res, r1);
    check("a5_bits", 0, seq, 8'hA5);
    check("a5_strobe_lat", 0, rv_lat, 9);
    check("a5_result", 0, res, 8'hA5);
    check("a5_ready_lat", 0, rdy_lat, 11);
    check("a5_gap0_ready_at_strobe", 1, r1, 1'b1);

    // 0x01 right: a single 1 goes out first, then zeros.
    run_word(8'h01, 1'b1, seq, rv_lat, rdy_lat, res, r1);
    check("r01_bits", 0, seq, 8'h80);
    check("r01_result", 0, res, 8'h01);

    // Back-to-back with valid held: GAP=0 instance strobes F0 then 0F ten cycles apart.
    wait_idle();
    strobes.delete();
    word  = 8'hF0;
    dir   = 1'b0;
    valid = 1'b1;
    step();
    word = 8'h0F;
    for (int k = 0; k < 30; k++) step();
    valid = 1'b0;
    wait_idle();
    n1 = 0;
    foreach (strobes[j])
      if (strobes[j].inst == 1 && n1 < 2) begin
        sc[n1] = strobes[j].c;
        sv[n1] = strobes[j].v;
        n1++;
      end
    check("b2b_count", 1, n1, 2);
    if (n1 == 2) begin
      check("b2b_spacing", 1, sc[1] - sc[0], 10);
      check("b2b_first", 1, sv[0], 8'hF0);
      check("b2b_second", 1, sv[1], 8'h0F);
    end

    // Abort sampled at the edge closing the 4th SHIFT cycle.
    wait_idle();
    strobes.delete();
    word  = 8'h5A;
    valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_sr_en", 0, sr_en[0], 1'b0);
    check("abort_ready", 0, ready[0], 1'b1);
    check("abort_result_kept", 0, result[0], 8'h0F);
    for (int k = 0; k < 15; k++) step();
    check("abort_no_strobe", 0, strobes.size(), 0);

    // Asynchronous reset between edges in the middle of a word.
    wait_idle();
    word  = 8'hC3;
    valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("mid_rst_sr_en", i, sr_en[i], 1'b0);
      check("mid_rst_ready", i, ready[i], 1'b1);
      check("mid_rst_busy", i, busy[i], 1'b0);
      check("mid_rst_result", i, result[i], '0);
      check("mid_rst_sr_data", i, sr_data[i], 1'b0);
    end
    model_reset();
    step();
    rst = 1'b0;
    run_word(8'h3C, 1'b1, seq, rv_lat, rdy_lat, res, r1);
    check("post_rst_result", 0, res, 8'h3C);
    check("post_rst_strobe_lat", 0, rv_lat, 9);

    // Random traffic with occasional aborts.
    for (int k = 0; k < 3000; k++) begin
      valid = ($urandom_range(0, 3) != 0);
      word  = W'($urandom);
      dir   = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 19) == 0);
      step();
    end
    valid = 1'b0;
    abort = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
